// File: rtl/x_ramb_pkg.sv
// Purpose: shared constants and elaboration helpers for the parametrised dual-port RAM model.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package x_ramb_pkg;

    // Per-port write-mode encodings
    localparam int WF = 0;  // WRITE_FIRST: output shows the data being written
    localparam int RF = 1;  // READ_FIRST: output shows the contents before the write
    localparam int NC = 2;  // NO_CHANGE: output holds during a write

    // Output-register reset value used when the instantiator does not override SRVAL
    localparam logic [63:0] SRVAL_DFLT = 64'h0;

    // Supported word widths
    function automatic bit width_ok(input int w);
        return (w >= 1) && (w <= 64);
    endfunction

    // Supported write-mode encodings
    function automatic bit wmode_ok(input int m);
        return (m >= WF) && (m <= NC);
    endfunction

endpackage

// File: rtl/x_ramb_port_out.sv
// Purpose: one RAM port's output path: write-mode select, stage-1 and optional stage-2 registers.
// Latency: 1 cycle to stage-1; 2 cycles when OUT_REG=1.
// Backpressure: none; stage-1 updates only when en=1, stage-2 follows stage-1 every cycle.
module x_ramb_port_out
    import x_ramb_pkg::*;
#(
    parameter int                DATA_W  = 4,
    parameter int                WMODE   = WF,
    parameter int                OUT_REG = 0,
    parameter logic [DATA_W-1:0] SRVAL   = SRVAL_DFLT[DATA_W-1:0]
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              en,
    input  logic              we,
    input  logic [DATA_W-1:0] di,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage1;
    logic [DATA_W-1:0] stage1_nxt;

    // Next stage-1 value: reads take the pre-write contents, writes follow the port's mode
    always_comb begin
        stage1_nxt = stage1;
        if (en) begin
            if (!we) begin
                stage1_nxt = rdata;
            end else if (WMODE == WF) begin
                stage1_nxt = di;
            end else if (WMODE == RF) begin
                stage1_nxt = rdata;
            end
        end
    end

    // Stage-1 register; reset wins over any same-cycle read
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            stage1 <= SRVAL;
        end else begin
            stage1 <= stage1_nxt;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] stage2;

        // Stage-2 register copies stage-1 unconditionally, so a read issued just before reset is lost
        always_ff @(posedge CLKA) begin
            if (RSTB) begin
                stage2 <= SRVAL;
            end else begin
                stage2 <= stage1;
            end
        end

        assign dout = stage2;
    end else begin : g_no_out_reg
        assign dout = stage1;
    end

endmodule

// File: rtl/x_ramb_dp_param.sv
// Purpose: true-dual-port RAM model on one clock, per-port write modes, same-address collision flag.
// Latency: read data 1 cycle after address sample (2 with OUT_REG=1); COLL 1 cycle after the conflict.
// Backpressure: none; both ports accept an access every cycle.
module x_ramb_dp_param
    import x_ramb_pkg::*;
#(
    parameter int                DATA_W  = 4,
    parameter int                ADDR_W  = 10,
    parameter int                WMODE_A = WF,
    parameter int                WMODE_B = WF,
    parameter int                OUT_REG = 0,
    parameter logic [DATA_W-1:0] SRVAL   = SRVAL_DFLT[DATA_W-1:0]
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              ENA,
    input  logic              WEA,
    input  logic [ADDR_W-1:0] ADDRA,
    input  logic [DATA_W-1:0] DIA,
    output logic [DATA_W-1:0] DOA,
    input  logic              ENB,
    input  logic              WEB,
    input  logic [ADDR_W-1:0] ADDRB,
    input  logic [DATA_W-1:0] DIB,
    output logic [DATA_W-1:0] DOB,
    output logic              COLL
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (!width_ok(DATA_W)) begin : g_bad_width
        $error("x_ramb_dp_param: DATA_W must be 1..64");
    end
    if (!wmode_ok(WMODE_A) || !wmode_ok(WMODE_B)) begin : g_bad_wmode
        $error("x_ramb_dp_param: WMODE_A/WMODE_B must be 0, 1 or 2");
    end

    // Array starts all-zero and is never touched by reset
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              wr_a;
    logic              wr_b;
    logic              coll_hit;

    // An unknown address never writes, so a floating bus cannot corrupt the array
    assign wr_a = ENA & WEA & !$isunknown(ADDRA);
    assign wr_b = ENB & WEB & !$isunknown(ADDRB);

    // Pre-write contents; both ports see old data even when the other port writes the same word
    assign rd_a = mem[ADDRA];
    assign rd_b = mem[ADDRB];

    // A conflict is a same-address access on both ports with at least one writer
    assign coll_hit = ENA & ENB & (ADDRA == ADDRB) & (WEA | WEB);

    // Array write; port A is applied last so it wins a same-address double write
    always_ff @(posedge CLKA) begin
        if (wr_b) begin
            mem[ADDRB] <= DIB;
        end
        if (wr_a) begin
            mem[ADDRA] <= DIA;
        end
    end

    // Collision flag, one pulse per conflicting cycle
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            COLL <= 1'b0;
        end else begin
            COLL <= coll_hit;
        end
    end

    x_ramb_port_out #(
        .DATA_W  (DATA_W),
        .WMODE   (WMODE_A),
        .OUT_REG (OUT_REG),
        .SRVAL   (SRVAL)
    ) u_port_a (
        .CLKA  (CLKA),
        .RSTB  (RSTB),
        .en    (ENA),
        .we    (WEA),
        .di    (DIA),
        .rdata (rd_a),
        .dout  (DOA)
    );

    x_ramb_port_out #(
        .DATA_W  (DATA_W),
        .WMODE   (WMODE_B),
        .OUT_REG (OUT_REG),
        .SRVAL   (SRVAL)
    ) u_port_b (
        .CLKA  (CLKA),
        .RSTB  (RSTB),
        .en    (ENB),
        .we    (WEB),
        .di    (DIB),
        .rdata (rd_b),
        .dout  (DOB)
    );

endmodule
